// File: rtl/mips_dmem_responder.sv
// Multi-cycle data-memory target for the MIPS datapath load/store port.
// Each request is latched, waits LATENCY cycles in BUSY, then answers with a one-cycle DONE pulse.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             rerr_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             accept;
  logic             do_access;
  logic             acc_err;
  logic [IDX_W-1:0] idx;

  assign accept    = (state_q == S_IDLE) && req_valid_i;
  assign do_access = (state_q == S_BUSY) && (cnt_q == 4'd0);

  // Error is derived from the latched address, so changes on req_addr_i during BUSY cannot leak in.
  // The range check uses the full 30-bit word index so high addresses never alias into the RAM.
  assign acc_err = (addr_q[1:0] != 2'b00) ||
                   ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign idx     = addr_q[IDX_W+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (do_access) begin
        rerr_q  <= acc_err;
        rdata_q <= (!acc_err && !wr_q) ? mem_q[idx] : 32'h0;
      end
    end
  end

  // Reset wipes the whole RAM; a store caught in BUSY by reset never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (do_access && wr_q && !acc_err) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE) && !reset;
  assign resp_valid_o = (state_q == S_DONE) && !reset;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = rerr_q;
  assign stall_o      = !reset &&
                        (((state_q == S_IDLE) && req_valid_i) || (state_q == S_BUSY));

endmodule
